// File: rtl/boot_loader_pkg.sv
// Shared widths, FSM encodings and UART defaults for the serial program loader.
package boot_loader_pkg;

  localparam int INST_ADDR_W     = 32;
  localparam int INST_W          = 32;
  localparam int DEFAULT_CLK_DIV = 434;

  typedef enum logic [2:0] {
    BootStLen  = 3'd0,
    BootStData = 3'd1,
    BootStCsum = 3'd2,
    BootStRun  = 3'd3,
    BootStErr  = 3'd4
  } boot_state_e;

  typedef enum logic [1:0] {
    RxIdle  = 2'd0,
    RxStart = 2'd1,
    RxData  = 2'd2,
    RxStop  = 2'd3
  } rx_state_e;

  // Byte address of word `index` in a word-addressed image starting at `base`.
  function automatic logic [INST_ADDR_W-1:0] wordByteAddr(
    input logic [INST_ADDR_W-1:0] base,
    input logic [INST_ADDR_W-1:0] index
  );
    return base + (index << 2);
  endfunction

endpackage

// File: rtl/boot_loader_uart_rx.sv
// 8N1 UART receiver: glitch-filtered start detection, centre sampling, framing errors dropped.
module uart_rx
  import boot_loader_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic       rx_valid,
  output logic [7:0] rx_data
);

  localparam int               CntW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0]  FullCnt = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0]  HalfCnt = CntW'(CLK_DIV / 2 - 1);

  rx_state_e       r_state;
  logic [CntW-1:0] r_cnt;
  logic [2:0]      r_bitIdx;
  logic [7:0]      r_shift;
  logic            r_rxPrev;
  logic            r_valid;

  // A start is only a falling edge; a line held low after a bad stop bit never re-triggers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= RxIdle;
      r_cnt    <= '0;
      r_bitIdx <= '0;
      r_shift  <= '0;
      r_rxPrev <= 1'b1;
      r_valid  <= 1'b0;
    end else begin
      r_valid  <= 1'b0;
      r_rxPrev <= rx_i;
      case (r_state)
        RxIdle: begin
          if (r_rxPrev && !rx_i) begin
            r_state <= RxStart;
            r_cnt   <= '0;
          end
        end
        RxStart: begin
          if (r_cnt == HalfCnt) begin
            r_cnt    <= '0;
            r_bitIdx <= '0;
            r_state  <= rx_i ? RxIdle : RxData;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RxData: begin
          if (r_cnt == FullCnt) begin
            r_cnt    <= '0;
            r_shift  <= {rx_i, r_shift[7:1]};
            r_bitIdx <= r_bitIdx + 3'd1;
            if (r_bitIdx == 3'd7) begin
              r_state <= RxStop;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RxStop: begin
          if (r_cnt == FullCnt) begin
            r_cnt   <= '0;
            r_state <= RxIdle;
            r_valid <= rx_i;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= RxIdle;
      endcase
    end
  end

  assign rx_valid = r_valid;
  assign rx_data  = r_shift;

endmodule

// File: rtl/boot_loader.sv
// UART program loader: writes a length-prefixed image into instruction memory, then releases the core.
// Optional trailing checksum byte is enabled with `define BOOT_LOADER_CHECKSUM_EN.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int                     CLK_DIV   = DEFAULT_CLK_DIV,
  parameter int                     MAX_WORDS = 1024,
  parameter logic [INST_ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   uart_rx_i,
  output logic                   ram_we_o,
  output logic [INST_ADDR_W-1:0] ram_addr_o,
  output logic [INST_W-1:0]      ram_data_o,
  output logic                   core_rst_o,
  output logic                   done_o,
  output logic                   err_o
);

  localparam int          WordCntW   = $clog2(MAX_WORDS + 1);
  localparam logic [31:0] MaxWords32 = 32'(MAX_WORDS);

  logic                   r_rxMeta;
  logic                   r_rxSync;
  logic                   w_rxValid;
  logic [7:0]             w_rxData;
  logic [31:0]            w_lenNext;
  logic                   w_lastWord;

  boot_state_e            r_state;
  logic [1:0]             r_byteCnt;
  logic [WordCntW-1:0]    r_wordCnt;
  logic [31:0]            r_len;
  logic [23:0]            r_asm;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [7:0]             r_csum;
`endif
  logic                   r_ramWe;
  logic [INST_ADDR_W-1:0] r_ramAddr;
  logic [INST_W-1:0]      r_ramData;
  logic                   r_coreRst;
  logic                   r_done;
  logic                   r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rxMeta <= 1'b1;
      r_rxSync <= 1'b1;
    end else begin
      r_rxMeta <= uart_rx_i;
      r_rxSync <= r_rxMeta;
    end
  end

  uart_rx #(
    .CLK_DIV(CLK_DIV)
  ) u_uartRx (
    .clk     (clk),
    .rst     (rst),
    .rx_i    (r_rxSync),
    .rx_valid(w_rxValid),
    .rx_data (w_rxData)
  );

  // Length and words arrive little-endian, so bytes shift in from the top.
  assign w_lenNext  = {w_rxData, r_len[31:8]};
  assign w_lastWord = (r_wordCnt + 1'b1) == r_len[WordCntW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= BootStLen;
      r_byteCnt <= '0;
      r_wordCnt <= '0;
      r_len     <= '0;
      r_asm     <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      r_csum    <= '0;
`endif
      r_ramWe   <= 1'b0;
      r_ramAddr <= BASE_ADDR;
      r_ramData <= '0;
      r_coreRst <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_ramWe <= 1'b0;
      case (r_state)
        BootStLen: begin
          if (w_rxValid) begin
            r_len     <= w_lenNext;
            r_byteCnt <= r_byteCnt + 2'd1;
            if (r_byteCnt == 2'd3) begin
              if (w_lenNext > MaxWords32) begin
                r_state <= BootStErr;
                r_err   <= 1'b1;
              end else if (w_lenNext == 32'd0) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                r_state   <= BootStCsum;
`else
                r_state   <= BootStRun;
                r_coreRst <= 1'b0;
                r_done    <= 1'b1;
`endif
              end else begin
                r_state <= BootStData;
              end
            end
          end
        end
        BootStData: begin
          if (w_rxValid) begin
            r_asm     <= {w_rxData, r_asm[23:8]};
            r_byteCnt <= r_byteCnt + 2'd1;
`ifdef BOOT_LOADER_CHECKSUM_EN
            r_csum    <= r_csum + w_rxData;
`endif
            if (r_byteCnt == 2'd3) begin
              r_ramWe   <= 1'b1;
              r_ramAddr <= wordByteAddr(BASE_ADDR, INST_ADDR_W'(r_wordCnt));
              r_ramData <= {w_rxData, r_asm};
              r_wordCnt <= r_wordCnt + 1'b1;
              // Release is deferred to RUN so it lands one cycle after the final write strobe.
              if (w_lastWord) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                r_state <= BootStCsum;
`else
                r_state <= BootStRun;
`endif
              end
            end
          end
        end
`ifdef BOOT_LOADER_CHECKSUM_EN
        BootStCsum: begin
          if (w_rxValid) begin
            if (w_rxData == r_csum) begin
              r_state   <= BootStRun;
              r_coreRst <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_state <= BootStErr;
              r_err   <= 1'b1;
            end
          end
        end
`endif
        BootStRun: begin
          r_coreRst <= 1'b0;
          r_done    <= 1'b1;
        end
        BootStErr: begin
          r_coreRst <= 1'b1;
          r_err     <= 1'b1;
        end
        default: begin
          r_state <= BootStErr;
          r_err   <= 1'b1;
        end
      endcase
    end
  end

  assign ram_we_o   = r_ramWe;
  assign ram_addr_o = r_ramAddr;
  assign ram_data_o = r_ramData;
  assign core_rst_o = r_coreRst;
  assign done_o     = r_done;
  assign err_o      = r_err;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: table-driven load sequence plus hand-written corner cases.
module tb_boot_loader;

  localparam int ClkDiv  = 16;
  localparam int KByte   = 0;
  localparam int KFrame  = 1;
  localparam int KGlitch = 2;
`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam bit CsumEn = 1'b1;
`else
  localparam bit CsumEn = 1'b0;
`endif

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         expWr;
    logic       expCoreRst;
    logic       expDone;
    logic       expErr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uartRx = 1'b1;
  logic        ramWe;
  logic [31:0] ramAddr;
  logic [31:0] ramData;
  logic        coreRst;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  boot_loader #(
    .CLK_DIV  (ClkDiv),
    .MAX_WORDS(1024),
    .BASE_ADDR(32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx_i (uartRx),
    .ram_we_o  (ramWe),
    .ram_addr_o(ramAddr),
    .ram_data_o(ramData),
    .core_rst_o(coreRst),
    .done_o    (done),
    .err_o     (err)
  );

  // Write-port monitor: captures every strobe and the cycles at which done/err rise.
  int          negCyc = 0;
  int          wrCount = 0;
  int          weDouble = 0;
  int          lastWeCyc = 0;
  int          doneCyc = 0;
  int          errCyc = 0;
  logic        prevWe = 1'b0;
  logic        prevDone = 1'b0;
  logic        prevErr = 1'b0;
  logic [31:0] wrAddr [0:63];
  logic [31:0] wrData [0:63];

  always @(negedge clk) begin
    negCyc <= negCyc + 1;
    if (ramWe) begin
      if (wrCount < 64) begin
        wrAddr[wrCount] <= ramAddr;
        wrData[wrCount] <= ramData;
      end
      wrCount   <= wrCount + 1;
      lastWeCyc <= negCyc;
      if (prevWe) weDouble <= weDouble + 1;
    end
    if (done && !prevDone) doneCyc <= negCyc;
    if (err && !prevErr) errCyc <= negCyc;
    prevWe   <= ramWe;
    prevDone <= done;
    prevErr  <= err;
  end

  int         checks = 0;
  int         errors = 0;
  vec_t       vecs [0:19];
  int         nVec = 0;
  logic [7:0] img [0:12];
  logic [7:0] expCsum;
  int         lastStopCyc = 0;
  int         wrBase;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic addVec(input int kind, input logic [7:0] data, input int expWr,
                        input logic expCoreRst, input logic expDone, input logic expErr);
    vecs[nVec].kind       = kind;
    vecs[nVec].data       = data;
    vecs[nVec].expWr      = expWr;
    vecs[nVec].expCoreRst = expCoreRst;
    vecs[nVec].expDone    = expDone;
    vecs[nVec].expErr     = expErr;
    nVec++;
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stopOk);
    uartRx = 1'b0;
    repeat (ClkDiv) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uartRx = b[i];
      repeat (ClkDiv) @(negedge clk);
    end
    lastStopCyc = negCyc;
    uartRx = stopOk;
    repeat (ClkDiv) @(negedge clk);
    uartRx = 1'b1;
    if (!stopOk) repeat (2 * ClkDiv) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic sendImage(input int first, input int last);
    for (int i = first; i <= last; i++) sendByte(img[i], 1'b1);
  endtask

  task automatic applyStimulus(input vec_t v);
    case (v.kind)
      KByte:  sendByte(v.data, 1'b1);
      KFrame: sendByte(v.data, 1'b0);
      default: begin
        uartRx = 1'b0;
        repeat (3) @(negedge clk);
        uartRx = 1'b1;
        repeat (3 * ClkDiv) @(negedge clk);
      end
    endcase
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    img = '{8'h02, 8'h00, 8'h00, 8'h00,
            8'h13, 8'h05, 8'h10, 8'h00,
            8'h93, 8'h05, 8'h20, 8'h00, 8'h00};
    // Model of the checksum: 8-bit sum of the payload bytes only (0xE0 for this image).
    expCsum = 8'h00;
    for (int i = 4; i < 12; i++) expCsum = expCsum + img[i];
    img[12] = expCsum;

    addVec(KByte,   8'h02, 0, 1'b1, 1'b0, 1'b0);
    addVec(KByte,   8'h00, 0, 1'b1, 1'b0, 1'b0);
    addVec(KByte,   8'h00, 0, 1'b1, 1'b0, 1'b0);
    addVec(KByte,   8'h00, 0, 1'b1, 1'b0, 1'b0);
    addVec(KByte,   8'h13, 0, 1'b1, 1'b0, 1'b0);
    addVec(KByte,   8'h05, 0, 1'b1, 1'b0, 1'b0);
    addVec(KFrame,  8'h10, 0, 1'b1, 1'b0, 1'b0);
    addVec(KByte,   8'h10, 0, 1'b1, 1'b0, 1'b0);
    addVec(KGlitch, 8'h00, 0, 1'b1, 1'b0, 1'b0);
    addVec(KByte,   8'h00, 1, 1'b1, 1'b0, 1'b0);
    addVec(KByte,   8'h93, 1, 1'b1, 1'b0, 1'b0);
    addVec(KByte,   8'h05, 1, 1'b1, 1'b0, 1'b0);
    addVec(KByte,   8'h20, 1, 1'b1, 1'b0, 1'b0);
    addVec(KByte,   8'h00, 2, CsumEn, !CsumEn, 1'b0);
    if (CsumEn) addVec(KByte, expCsum, 2, 1'b0, 1'b1, 1'b0);
    addVec(KByte,   8'h55, 2, 1'b0, 1'b1, 1'b0);

    $display("[TB] reset state");
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkBit("resetCoreRst", coreRst, 1'b1);
    checkBit("resetDone", done, 1'b0);
    checkBit("resetErr", err, 1'b0);
    checkBit("resetWe", ramWe, 1'b0);
    checkOutput("resetAddr", ramAddr, 32'h0);
    checkOutput("resetData", ramData, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] two-word load with framing error and glitch");
    wrBase = wrCount;
    for (int i = 0; i < nVec; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_writes", i), 32'(wrCount - wrBase), 32'(vecs[i].expWr));
      checkBit($sformatf("vec%0d_coreRst", i), coreRst, vecs[i].expCoreRst);
      checkBit($sformatf("vec%0d_done", i), done, vecs[i].expDone);
      checkBit($sformatf("vec%0d_err", i), err, vecs[i].expErr);
    end
    checkOutput("wr0Addr", wrAddr[wrBase], 32'h0000_0000);
    checkOutput("wr0Data", wrData[wrBase], 32'h0010_0513);
    checkOutput("wr1Addr", wrAddr[wrBase + 1], 32'h0000_0004);
    checkOutput("wr1Data", wrData[wrBase + 1], 32'h0020_0593);
    checkOutput("weSingleCycle", 32'(weDouble), 32'd0);
`ifdef BOOT_LOADER_CHECKSUM_EN
    checkBit("doneAfterWrites", doneCyc > lastWeCyc, 1'b1);
`else
    checkOutput("doneGap", 32'(doneCyc - lastWeCyc), 32'd1);
`endif

`ifdef BOOT_LOADER_CHECKSUM_EN
    $display("[TB] bad checksum");
    pulseReset();
    wrBase = wrCount;
    sendImage(0, 11);
    sendByte(8'h36, 1'b1);
    checkBit("badCsumErr", err, 1'b1);
    checkBit("badCsumCoreRst", coreRst, 1'b1);
    checkBit("badCsumDone", done, 1'b0);
    checkOutput("badCsumWrites", 32'(wrCount - wrBase), 32'd2);
`endif

    $display("[TB] oversize length");
    pulseReset();
    wrBase = wrCount;
    sendByte(8'h01, 1'b1);
    sendByte(8'h04, 1'b1);
    sendByte(8'h00, 1'b1);
    checkBit("oversizeErrBefore", err, 1'b0);
    sendByte(8'h00, 1'b1);
    checkBit("oversizeErr", err, 1'b1);
    checkBit("oversizeCoreRst", coreRst, 1'b1);
    checkBit("oversizeErrWindow", (errCyc - lastStopCyc >= 2) && (errCyc - lastStopCyc <= ClkDiv), 1'b1);
    sendImage(0, 7);
    checkOutput("oversizeWrites", 32'(wrCount - wrBase), 32'd0);
    checkBit("oversizeErrSticky", err, 1'b1);
    checkBit("oversizeDone", done, 1'b0);

    $display("[TB] reset mid-load");
    pulseReset();
    wrBase = wrCount;
    sendImage(0, 9);
    checkOutput("midLoadWrites", 32'(wrCount - wrBase), 32'd1);
    pulseReset();
    checkBit("midResetCoreRst", coreRst, 1'b1);
    checkBit("midResetDone", done, 1'b0);
    checkBit("midResetErr", err, 1'b0);
    checkOutput("midResetAddr", ramAddr, 32'h0);
    wrBase = wrCount;
    sendImage(0, CsumEn ? 12 : 11);
    checkOutput("reloadWrites", 32'(wrCount - wrBase), 32'd2);
    checkOutput("reloadWr0Addr", wrAddr[wrBase], 32'h0000_0000);
    checkOutput("reloadWr0Data", wrData[wrBase], 32'h0010_0513);
    checkOutput("reloadWr1Data", wrData[wrBase + 1], 32'h0020_0593);
    checkBit("reloadDone", done, 1'b1);
    checkBit("reloadCoreRst", coreRst, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
